uart_word_tx: RTL

- Transmit-side counterpart of the UART receive/word-assembly path: accepts one 64-bit word per valid/ready handshake and serialises it as 8 consecutive UART 8N1 frames on tx.
- Sits between application logic (e.g. an echo/increment path) and the board's USB-RS232 Tx pin.
- Contains its own baud-period counter, so it has no dependency on the receive-side timing.

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_baud_gen.sv | 42 ++++
 rtl/uart_word_tx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the word-level UART transmitter.
//   - State codes (IDLE/START/DATA/STOP/PARITY) as localparams plus the enum built on them.
//   - DATA_BITS: data bits per UART frame.
//   - calc_div / calc_cnt_w: bit period in clocks and the baud counter width.
//   - even_parity: XOR of a data byte. It is used only when UART_WORD_TX_PARITY_EN is defined.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        STOP   = ST_STOP,
        PARITY = ST_PARITY
    } state_t;

    localparam int DATA_BITS = 8;

    // Bit period in clocks. The result is truncated and never drops below one clock.
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = (baud > 0) ? (clk_hz / baud) : 1;
        return (d < 1) ? 1 : d;
    endfunction

    // Baud counter width, kept at least 1 bit so that DIV=1 still yields a legal vector.
    function automatic int calc_cnt_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    // Even parity: the bit that makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [7:0] data_byte);
        return ^data_byte;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer for the transmitter.
//   The counter runs 0..DIV-1 and wraps. clr restarts it at 0, so the first bit of a word
//   starts exactly on the acceptance edge.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   clr      in   synchronous restart of the count
//   bit_tick out  high during the last clock of each bit period (count == DIV-1)
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV   = 10,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic bit_tick
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // The terminal count is decoded directly from the counter register.
    assign bit_tick = (cnt_r == TERM);

    // Bit-period counter: clear on request, wrap at the terminal count, otherwise increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (bit_tick) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + ONE;
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// uart_word_tx: accepts a word through a valid/ready handshake and sends it as consecutive
// UART frames, byte 0 first. Each frame is 8N1.
// Optional macro UART_WORD_TX_PARITY_EN: when defined, an even-parity bit is inserted after
//   data bit 7, giving 11-bit frames.
// Ports:
//   clk_100MHz  in   system clock (rising edge)
//   reset       in   asynchronous active-low reset
//   wr_data     in   word to send; it is latched on acceptance
//   wr_valid    in   producer offers wr_data
//   wr_ready    out  high only in IDLE
//   tx          out  serial line, idle high, registered
//   busy        out  high from acceptance until the return to IDLE
//   done_tick   out  one-cycle pulse after the final stop bit
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 9600,
    parameter int WORD_BYTES = 8
) (
    input  logic                      clk_100MHz,
    input  logic                      reset,
    input  logic [8*WORD_BYTES-1:0]   wr_data,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    output logic                      tx,
    output logic                      busy,
    output logic                      done_tick
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int CNT_W = calc_cnt_w(DIV);
    localparam int W     = 8 * WORD_BYTES;
    localparam logic [2:0] LAST_BYTE = 3'(WORD_BYTES - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    state_t         state_r;
    logic [W-1:0]   shreg_r;
    logic [2:0]     byte_cnt_r;
    logic [2:0]     bit_cnt_r;
    logic           tx_r;
    logic           wr_ready_r;
    logic           busy_r;
    logic           done_r;

    logic           accept_s;
    logic           bit_tick_s;
    logic [7:0]     cur_byte_s;
    logic           next_bit_s;

    // The byte in flight always sits in the low byte of the shift register. Later bytes
    // move down only between frames.
    assign cur_byte_s = shreg_r[7:0];
    assign next_bit_s = cur_byte_s[bit_cnt_r + 3'd1];
    assign accept_s   = wr_valid && wr_ready_r && (state_r == IDLE);

    assign wr_ready  = wr_ready_r;
    assign tx        = tx_r;
    assign busy      = busy_r;
    assign done_tick = done_r;

    // The timer restarts on acceptance. Frames within a word follow back to back on the free-running period.
    uart_baud_gen #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_baud (
        .clk      (clk_100MHz),
        .rst_n    (reset),
        .clr      (accept_s),
        .bit_tick (bit_tick_s)
    );

    // Transmit FSM. Every output is registered, so tx changes on the same edge as the state.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            shreg_r    <= '0;
            byte_cnt_r <= 3'd0;
            bit_cnt_r  <= 3'd0;
            tx_r       <= 1'b1;
            wr_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    tx_r <= 1'b1;
                    if (accept_s) begin
                        shreg_r    <= wr_data;
                        byte_cnt_r <= 3'd0;
                        bit_cnt_r  <= 3'd0;
                        tx_r       <= 1'b0;
                        busy_r     <= 1'b1;
                        wr_ready_r <= 1'b0;
                        state_r    <= START;
                    end
                end
                START: begin
                    if (bit_tick_s) begin
                        bit_cnt_r <= 3'd0;
                        tx_r      <= cur_byte_s[0];
                        state_r   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick_s) begin
                        if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_WORD_TX_PARITY_EN
                            tx_r    <= even_parity(cur_byte_s);
                            state_r <= PARITY;
`else
                            tx_r    <= 1'b1;
                            state_r <= STOP;
`endif
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            tx_r      <= next_bit_s;
                        end
                    end
                end
`ifdef UART_WORD_TX_PARITY_EN
                PARITY: begin
                    if (bit_tick_s) begin
                        tx_r    <= 1'b1;
                        state_r <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_tick_s) begin
                        if (byte_cnt_r != LAST_BYTE) begin
                            // The next frame's start bit begins on this same edge, with no gap.
                            byte_cnt_r <= byte_cnt_r + 3'd1;
                            shreg_r    <= {8'h00, shreg_r[W-1:8]};
                            tx_r       <= 1'b0;
                            state_r    <= START;
                        end else begin
                            tx_r       <= 1'b1;
                            done_r     <= 1'b1;
                            busy_r     <= 1'b0;
                            wr_ready_r <= 1'b1;
                            state_r    <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_r       <= 1'b1;
                    busy_r     <= 1'b0;
                    wr_ready_r <= 1'b1;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule
